eye_tracker_reg_bank: RTL and testbench

- Parametrised successor to the EyeTracker control register block.
- Address-decoded host register bank with:
  - registered read data and a read-valid strobe
  - W1C sticky event status with an interrupt output
  - NUM_THR threshold channels, shadowed so active values change only on frame boundaries
- Sits between HOST_IF (UART command decoder) and the image pipeline: UART switch, VGA mode, per-channel thresholds.

---
 rtl/eye_tracker_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_eye_tracker_reg_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eye_tracker_reg_bank.sv
// eye_tracker_reg_bank
//   Host-facing control/status register bank for the EyeTracker pipeline.
//   It sits between the UART command decoder and the image pipeline.
//
//   Address map (ADDR_WIDTH-wide word addresses):
//     0            CTRL    bit0 UART_SW, bit1 VGA_OUT_MODE, bit2 SHADOW_EN (R/W)
//     1            STATUS  sticky event bits, write-1-to-clear
//     2            IRQ_EN  per-event interrupt enables (R/W)
//     3            INFO    read-only, returns NUM_THR
//     4..4+NUM_THR-1  THR  pending threshold registers (R/W)
//     any other address is unmapped
//
//   Ports:
//     CLK, RST           clock, synchronous active-high reset
//     iWE, iRE           single-cycle host write / read strobes
//     iADDR, iDATA       host address / write data
//     oRD, oRD_VALID     registered read data + one-cycle valid strobe
//     oADDR_ERR          one-cycle pulse after an unmapped access
//     iFRAME_START       frame boundary pulse (shadow transfer point)
//     iEVENT             event pulses captured into STATUS
//     oIRQ               level interrupt, OR of (STATUS & IRQ_EN)
//     oUART_SW           CTRL bit0
//     oVGA_OUT_MODE      CTRL bit1
//     oTHRESHOLD         active thresholds, channel k at [k*DATA_WIDTH +: DATA_WIDTH]

// One threshold channel: host-written pending value plus the active copy
// that the image pipeline actually sees.
module eye_tracker_thr_chan #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] THR_INIT   = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] pend,
  output logic [DATA_WIDTH-1:0] act
);

  // act samples the pre-edge pend, so a write landing on a load edge
  // is only picked up by the following load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= THR_INIT;
      act  <= THR_INIT;
    end else begin
      if (we)   pend <= wdata;
      if (load) act  <= pend;
    end
  end

endmodule

module eye_tracker_reg_bank #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    NUM_THR    = 4,
  parameter int                    EVT_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] THR_INIT   = 8'h01
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          iWE,
  input  logic                          iRE,
  input  logic [ADDR_WIDTH-1:0]         iADDR,
  input  logic [DATA_WIDTH-1:0]         iDATA,
  output logic [DATA_WIDTH-1:0]         oRD,
  output logic                          oRD_VALID,
  output logic                          oADDR_ERR,
  input  logic                          iFRAME_START,
  input  logic [EVT_WIDTH-1:0]          iEVENT,
  output logic                          oIRQ,
  output logic                          oUART_SW,
  output logic                          oVGA_OUT_MODE,
  output logic [NUM_THR*DATA_WIDTH-1:0] oTHRESHOLD
);

  localparam logic [2:0] CTRL_RST = 3'b110;

  logic [2:0]                           ctrl;
  logic [EVT_WIDTH-1:0]                 status;
  logic [EVT_WIDTH-1:0]                 irq_en;
  logic [EVT_WIDTH-1:0]                 status_clr;
  logic [NUM_THR-1:0][DATA_WIDTH-1:0]   pend_q;
  logic [NUM_THR-1:0][DATA_WIDTH-1:0]   act_q;
  logic [NUM_THR-1:0]                   thr_we;
  logic                                 sel_ctrl, sel_status, sel_irq_en, sel_info;
  logic                                 thr_hit, mapped, shadow_load;
  logic [DATA_WIDTH-1:0]                rd_mux;

  assign sel_ctrl   = (iADDR == ADDR_WIDTH'(0));
  assign sel_status = (iADDR == ADDR_WIDTH'(1));
  assign sel_irq_en = (iADDR == ADDR_WIDTH'(2));
  assign sel_info   = (iADDR == ADDR_WIDTH'(3));

  // Threshold decode and read mux. Unmapped addresses fall through to 0,
  // which is exactly what an unmapped read must return.
  always_comb begin
    thr_hit = 1'b0;
    thr_we  = '0;
    rd_mux  = '0;
    if (sel_ctrl)   rd_mux = DATA_WIDTH'(ctrl);
    if (sel_status) rd_mux = DATA_WIDTH'(status);
    if (sel_irq_en) rd_mux = DATA_WIDTH'(irq_en);
    if (sel_info)   rd_mux = DATA_WIDTH'(NUM_THR);
    for (int k = 0; k < NUM_THR; k++) begin
      if (iADDR == ADDR_WIDTH'(4 + k)) begin
        thr_hit   = 1'b1;
        thr_we[k] = iWE;
        rd_mux    = pend_q[k];
      end
    end
  end

  assign mapped     = sel_ctrl | sel_status | sel_irq_en | sel_info | thr_hit;
  assign status_clr = (iWE && sel_status) ? iDATA[EVT_WIDTH-1:0] : '0;

  // With shadowing off the active copy tracks pending one cycle behind.
  assign shadow_load = ctrl[2] ? iFRAME_START : 1'b1;

  generate
    for (genvar k = 0; k < NUM_THR; k++) begin : g_thr
      eye_tracker_thr_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .THR_INIT   (THR_INIT)
      ) u_chan (
        .clk   (CLK),
        .rst   (RST),
        .we    (thr_we[k]),
        .load  (shadow_load),
        .wdata (iDATA),
        .pend  (pend_q[k]),
        .act   (act_q[k])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl      <= CTRL_RST;
      status    <= '0;
      irq_en    <= '0;
      oRD       <= '0;
      oRD_VALID <= 1'b0;
      oADDR_ERR <= 1'b0;
    end else begin
      if (iWE && sel_ctrl)   ctrl   <= iDATA[2:0];
      if (iWE && sel_irq_en) irq_en <= iDATA[EVT_WIDTH-1:0];
      // Event set wins over a same-cycle W1C clear.
      status    <= (status & ~status_clr) | iEVENT;
      // rd_mux reflects pre-edge state, so a same-cycle write is not seen.
      if (iRE) oRD <= rd_mux;
      oRD_VALID <= iRE;
      oADDR_ERR <= (iWE | iRE) & ~mapped;
    end
  end

  assign oIRQ          = |(status & irq_en);
  assign oUART_SW      = ctrl[0];
  assign oVGA_OUT_MODE = ctrl[1];
  assign oTHRESHOLD    = act_q;

endmodule

// File: tb/tb_eye_tracker_reg_bank.sv
// Bench for eye_tracker_reg_bank (default parameters: 8-bit data, 4-bit
// address, 4 thresholds, 4 events). A table of per-cycle vectors is applied
// one per clock; read expectations go through a queue that is drained when
// oRD_VALID shows up, other outputs are checked every cycle.
module tb_eye_tracker_reg_bank;

  typedef struct {
    logic        rst, we, re;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        frame;
    logic [3:0]  evt;
    logic [7:0]  rd;
    logic        err, irq, uart, vga;
    logic [31:0] thr;
  } vec_t;

  logic        clk = 1'b0;
  logic        RST, iWE, iRE, iFRAME_START;
  logic [3:0]  iADDR, iEVENT;
  logic [7:0]  iDATA, oRD;
  logic        oRD_VALID, oADDR_ERR, oIRQ, oUART_SW, oVGA_OUT_MODE;
  logic [31:0] oTHRESHOLD;

  int          tests = 0;
  int          fails = 0;
  int          cur_idx = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  last_rd = 8'h00;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  eye_tracker_reg_bank dut (
    .CLK           (clk),
    .RST           (RST),
    .iWE           (iWE),
    .iRE           (iRE),
    .iADDR         (iADDR),
    .iDATA         (iDATA),
    .oRD           (oRD),
    .oRD_VALID     (oRD_VALID),
    .oADDR_ERR     (oADDR_ERR),
    .iFRAME_START  (iFRAME_START),
    .iEVENT        (iEVENT),
    .oIRQ          (oIRQ),
    .oUART_SW      (oUART_SW),
    .oVGA_OUT_MODE (oVGA_OUT_MODE),
    .oTHRESHOLD    (oTHRESHOLD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", cur_idx, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, we, re, input logic [3:0] addr,
                              input logic [7:0] data, input logic frame,
                              input logic [3:0] evt, input logic [7:0] rd,
                              input logic err, irq, uart, vga,
                              input logic [31:0] thr);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.data = data;
    v.frame = frame; v.evt = evt; v.rd = rd; v.err = err; v.irq = irq;
    v.uart = uart; v.vga = vga; v.thr = thr;
    return v;
  endfunction

  // Drive one vector (inputs settle mid-low-phase), clock it, then check
  // the registered outputs on the following falling edge.
  task automatic step(input vec_t v);
    logic       exp_vld;
    logic [7:0] exp_rd;
    RST = v.rst; iWE = v.we; iRE = v.re; iADDR = v.addr; iDATA = v.data;
    iFRAME_START = v.frame; iEVENT = v.evt;
    exp_vld = v.re && !v.rst;
    if (exp_vld) rd_q.push_back(v.rd);
    @(posedge clk);
    @(negedge clk);
    check("rd_valid", {31'd0, oRD_VALID}, {31'd0, exp_vld});
    if (oRD_VALID) begin
      if (rd_q.size() > 0) begin
        exp_rd = rd_q.pop_front();
        check("rd_data", {24'd0, oRD}, {24'd0, exp_rd});
        last_rd = exp_rd;
      end else begin
        check("rd_spurious", 32'd1, 32'd0);
      end
    end else begin
      if (rd_q.size() > 0) exp_rd = rd_q.pop_front();
      if (v.rst) last_rd = 8'h00;
      check("rd_hold", {24'd0, oRD}, {24'd0, last_rd});
    end
    check("addr_err", {31'd0, oADDR_ERR},     {31'd0, v.err});
    check("irq",      {31'd0, oIRQ},          {31'd0, v.irq});
    check("uart_sw",  {31'd0, oUART_SW},      {31'd0, v.uart});
    check("vga_mode", {31'd0, oVGA_OUT_MODE}, {31'd0, v.vga});
    check("thr",      oTHRESHOLD,             v.thr);
    cur_idx++;
  endtask

  initial begin
    logic [7:0]  rv [4];
    logic [31:0] thr_new;
    logic [7:0]  rd_exp [8];
    rd_exp[0] = 8'h06; rd_exp[1] = 8'h00; rd_exp[2] = 8'h00; rd_exp[3] = 8'h04;
    rd_exp[4] = 8'h01; rd_exp[5] = 8'h01; rd_exp[6] = 8'h01; rd_exp[7] = 8'h01;

    RST = 1'b1; iWE = 1'b0; iRE = 1'b0; iADDR = '0; iDATA = '0;
    iFRAME_START = 1'b0; iEVENT = '0;
    @(negedge clk);

    //             rst we re addr data  fr evt  | rd   err irq uart vga thr
    tbl.push_back(mk(1, 0, 0, 4'd0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01010101));
    for (int a = 0; a < 8; a++)
      tbl.push_back(mk(0, 0, 1, 4'(a), 8'h00, 0, 4'h0, rd_exp[a], 0, 0, 0, 1, 32'h01010101));
    // shadowed threshold write, frame transfer
    tbl.push_back(mk(0, 1, 0, 4'd6, 8'hA5, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01010101));
    tbl.push_back(mk(0, 0, 1, 4'd6, 8'h00, 0, 4'h0, 8'hA5, 0, 0, 0, 1, 32'h01010101));
    tbl.push_back(mk(0, 0, 0, 4'd0, 8'h00, 1, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50101));
    // write coinciding with frame start is deferred to the next frame
    tbl.push_back(mk(0, 1, 0, 4'd4, 8'h33, 1, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50101));
    tbl.push_back(mk(0, 0, 1, 4'd4, 8'h00, 0, 4'h0, 8'h33, 0, 0, 0, 1, 32'h01A50101));
    tbl.push_back(mk(0, 0, 0, 4'd0, 8'h00, 1, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    // sticky status, W1C vs set, interrupt
    tbl.push_back(mk(0, 1, 0, 4'd2, 8'h01, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 4'h1, 8'h00, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd1, 8'h00, 0, 4'h0, 8'h01, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd1, 8'h01, 0, 4'h1, 8'h00, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd1, 8'h00, 0, 4'h0, 8'h01, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd1, 8'h01, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd1, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    // masked event, then enable over it
    tbl.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 4'h2, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd2, 8'h03, 0, 4'h0, 8'h00, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd2, 8'h00, 0, 4'h0, 8'h03, 0, 1, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd1, 8'h02, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    // unmapped accesses
    tbl.push_back(mk(0, 1, 0, 4'd12, 8'h5A, 0, 4'h0, 8'h00, 1, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd12, 8'h00, 0, 4'h0, 8'h00, 1, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd0, 8'h00, 0, 4'h0, 8'h06, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd15, 8'hFF, 0, 4'h0, 8'h00, 1, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 1, 4'd3, 8'h00, 0, 4'h0, 8'h04, 0, 0, 0, 1, 32'h01A50133));
    // shadow off: active trails pending by one cycle
    tbl.push_back(mk(0, 1, 0, 4'd0, 8'h02, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 1, 0, 4'd5, 8'h77, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A50133));
    tbl.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A57733));
    tbl.push_back(mk(0, 1, 0, 4'd0, 8'h06, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01A57733));
    // same-cycle write+read returns pre-write CTRL
    tbl.push_back(mk(0, 1, 1, 4'd0, 8'h01, 0, 4'h0, 8'h06, 0, 0, 1, 0, 32'h01A57733));
    // reset overrides write, read, event and frame
    tbl.push_back(mk(1, 1, 1, 4'd4, 8'hFF, 1, 4'hF, 8'h00, 0, 0, 0, 1, 32'h01010101));
    tbl.push_back(mk(0, 0, 1, 4'd4, 8'h00, 0, 4'h0, 8'h01, 0, 0, 0, 1, 32'h01010101));
    tbl.push_back(mk(0, 0, 1, 4'd1, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01010101));
    tbl.push_back(mk(0, 0, 1, 4'd0, 8'h00, 0, 4'h0, 8'h06, 0, 0, 0, 1, 32'h01010101));

    foreach (tbl[i]) step(tbl[i]);

    // Back-to-back threshold writes then reads with random data, then a frame.
    for (int k = 0; k < 4; k++) rv[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++)
      step(mk(0, 1, 0, 4'(4 + k), rv[k], 0, 4'h0, 8'h00, 0, 0, 0, 1, 32'h01010101));
    for (int k = 0; k < 4; k++)
      step(mk(0, 0, 1, 4'(4 + k), 8'h00, 0, 4'h0, rv[k], 0, 0, 0, 1, 32'h01010101));
    thr_new = {rv[3], rv[2], rv[1], rv[0]};
    step(mk(0, 0, 0, 4'd0, 8'h00, 1, 4'h0, 8'h00, 0, 0, 0, 1, thr_new));
    step(mk(0, 0, 0, 4'd0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1, thr_new));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
